// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
// Holds the user data window bounds and the response-port encodings.
package dmem_arbiter_pkg;

  // User data window (inclusive bounds, byte addresses).
  localparam logic [31:0] BEGINNING_DATA = 32'h0000_2000;
  localparam logic [31:0] END_DATA       = 32'h0000_2FFF;

  // Encodings for the response-stage port tag.
  localparam logic [1:0] DMEM_PORT_NONE = 2'd0;
  localparam logic [1:0] DMEM_PORT_C    = 2'd1;
  localparam logic [1:0] DMEM_PORT_D    = 2'd2;

  typedef enum logic [1:0] {
    PORT_NONE = DMEM_PORT_NONE,
    PORT_C    = DMEM_PORT_C,
    PORT_D    = DMEM_PORT_D
  } dmem_port_e;

  // Unsigned 32-bit window check.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= BEGINNING_DATA) && (addr <= END_DATA);
  endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// Starvation counter for the DMA/debug port.
// Counts contested cycles lost by port D and flags when D must win.
module dmem_starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [3:0] MaxWaitQ = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  // Next count: clear on a D grant, otherwise saturating increment.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = 4'd0;
    end else if (inc && (wait_cnt_q != MaxWaitQ)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expired = (wait_cnt_q == MaxWaitQ);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data memory.
// Port C (load/store unit) has priority; port D (DMA/debug) is granted
// once it has lost MAX_WAIT contested cycles. One response per grant,
// returned exactly one cycle later; back-to-back grants are allowed.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iCReq,
  input  logic                    iCWe,
  input  logic [3:0]              iCBe,
  input  logic [31:0]             iCAddr,
  input  logic [31:0]             iCWData,
  input  logic                    iDReq,
  input  logic                    iDWe,
  input  logic [3:0]              iDBe,
  input  logic [31:0]             iDAddr,
  input  logic [31:0]             iDWData,
  output logic                    oCGnt,
  output logic                    oDGnt,
  output logic                    oCRValid,
  output logic                    oDRValid,
  output logic [31:0]             oCRData,
  output logic [31:0]             oDRData,
  output logic                    oCErr,
  output logic                    oDErr,
  output logic [DATA_WIDTH-3:0]   oMemAddr,
  output logic [3:0]              oMemBe,
  output logic [31:0]             oMemWData,
  output logic                    oMemWren,
  input  logic [31:0]             iMemQ
);

  logic        expired;
  logic        c_gnt;
  logic        d_gnt;
  logic        gnt_any;
  logic        sel_we;
  logic        sel_in_win;
  logic [31:0] sel_addr;
  logic [31:0] word_off;
  logic        unused_off_bits;

  dmem_port_e  rsp_port_q, rsp_port_d;
  logic        rsp_rd_q,   rsp_rd_d;
  logic        rsp_err_q,  rsp_err_d;

  dmem_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .inc     (iDReq && !d_gnt),
    .clr     (d_gnt),
    .expired (expired)
  );

  // Arbitration and command mux; no grant while reset is held.
  always_comb begin
    d_gnt      = iRST_N && iDReq && (!iCReq || expired);
    c_gnt      = iRST_N && iCReq && !d_gnt;
    gnt_any    = c_gnt || d_gnt;
    sel_addr   = d_gnt ? iDAddr  : iCAddr;
    sel_we     = d_gnt ? iDWe    : iCWe;
    oMemBe     = d_gnt ? iDBe    : iCBe;
    oMemWData  = d_gnt ? iDWData : iCWData;
    sel_in_win = in_window(sel_addr);
    word_off   = sel_addr - BEGINNING_DATA;
    oMemAddr   = word_off[DATA_WIDTH-1:2];
    oMemWren   = gnt_any && sel_we && sel_in_win;
  end

  assign oCGnt = c_gnt;
  assign oDGnt = d_gnt;

  // Byte-offset and above-window bits of the offset are not part of the word address.
  assign unused_off_bits = ^{word_off[31:DATA_WIDTH], word_off[1:0]};

  // Response-stage next state, loaded every cycle.
  always_comb begin
    rsp_port_d = c_gnt ? PORT_C : (d_gnt ? PORT_D : PORT_NONE);
    rsp_rd_d   = gnt_any && !sel_we && sel_in_win;
    rsp_err_d  = !sel_in_win;
  end

  // Response-stage registers; reset discards any pending response.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rsp_port_q <= PORT_NONE;
      rsp_rd_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_port_q <= rsp_port_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Response steering: memory data only reaches the winner of a read.
  always_comb begin
    oCRValid = (rsp_port_q == PORT_C);
    oDRValid = (rsp_port_q == PORT_D);
    oCErr    = oCRValid && rsp_err_q;
    oDErr    = oDRValid && rsp_err_q;
    oCRData  = (oCRValid && rsp_rd_q) ? iMemQ : 32'd0;
    oDRData  = (oDRValid && rsp_rd_q) ? iMemQ : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

  localparam int          DW   = 12;
  localparam logic [31:0] BEG  = 32'h0000_2000;
  localparam logic [31:0] ENDD = 32'h0000_2FFF;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iCReq, iCWe, iDReq, iDWe;
  logic [3:0]    iCBe, iDBe;
  logic [31:0]   iCAddr, iCWData, iDAddr, iDWData;
  logic          oCGnt, oDGnt, oCRValid, oDRValid, oCErr, oDErr;
  logic [31:0]   oCRData, oDRData;
  logic [DW-3:0] oMemAddr;
  logic [3:0]    oMemBe;
  logic [31:0]   oMemWData;
  logic          oMemWren;
  logic [31:0]   iMemQ;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  dmem_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iCReq(iCReq), .iCWe(iCWe), .iCBe(iCBe), .iCAddr(iCAddr), .iCWData(iCWData),
    .iDReq(iDReq), .iDWe(iDWe), .iDBe(iDBe), .iDAddr(iDAddr), .iDWData(iDWData),
    .oCGnt(oCGnt), .oDGnt(oDGnt), .oCRValid(oCRValid), .oDRValid(oDRValid),
    .oCRData(oCRData), .oDRData(oDRData), .oCErr(oCErr), .oDErr(oDErr),
    .oMemAddr(oMemAddr), .oMemBe(oMemBe), .oMemWData(oMemWData),
    .oMemWren(oMemWren), .iMemQ(iMemQ)
  );

  // Behavioural single-port memory, 1-cycle read latency, byte enables.
  logic [31:0] mem [0:(1<<(DW-2))-1];
  logic        init_mem;
  always @(posedge iCLK) begin
    if (init_mem) begin
      for (int i = 0; i < (1 << (DW - 2)); i++) mem[i] <= (i == 2) ? 32'hDEADBEEF : 32'd0;
    end else if (oMemWren) begin
      for (int b = 0; b < 4; b++) if (oMemBe[b]) mem[oMemAddr][8*b +: 8] <= oMemWData[8*b +: 8];
    end
    iMemQ <= mem[oMemAddr];
  end

  // Reference memory and response scoreboard.
  logic [31:0] ref_mem [0:(1<<(DW-2))-1];

  typedef struct {
    logic [1:0]  port;   // 0 none, 1 C, 2 D
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t sbq[$];

  typedef struct {
    logic creq, cwe; logic [3:0] cbe; logic [31:0] caddr, cwd;
    logic dreq, dwe; logic [3:0] dbe; logic [31:0] daddr, dwd;
    logic ecg, edg, ewr; logic [DW-3:0] ema;
  } vec_t;
  vec_t vt [16];

  function automatic vec_t mk(
    input logic creq, cwe, input logic [3:0] cbe, input logic [31:0] caddr, cwd,
    input logic dreq, dwe, input logic [3:0] dbe, input logic [31:0] daddr, dwd,
    input logic ecg, edg, ewr, input logic [DW-3:0] ema);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.cbe = cbe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dbe = dbe; v.daddr = daddr; v.dwd = dwd;
    v.ecg = ecg; v.edg = edg; v.ewr = ewr; v.ema = ema;
    return v;
  endfunction

  task automatic drive(
    input logic creq, cwe, input logic [3:0] cbe, input logic [31:0] caddr, cwd,
    input logic dreq, dwe, input logic [3:0] dbe, input logic [31:0] daddr, dwd);
    iCReq = creq; iCWe = cwe; iCBe = cbe; iCAddr = caddr; iCWData = cwd;
    iDReq = dreq; iDWe = dwe; iDBe = dbe; iDAddr = daddr; iDWData = dwd;
  endtask

  task automatic drive_idle();
    drive(0, 0, 4'h0, BEG, 32'd0, 0, 0, 4'h0, BEG, 32'd0);
  endtask

  task automatic drive_contend();
    drive(1, 0, 4'hF, BEG + 32'd8, 32'd0, 1, 0, 4'hF, BEG + 32'd4, 32'd0);
  endtask

  // Compare this cycle's response outputs with the oldest scoreboard entry.
  task automatic check_resp(input int tag);
    rsp_t e;
    logic        ecv, edv, ece, ede;
    logic [31:0] ecd, edd;
    if (sbq.size() > 0) e = sbq.pop_front();
    else begin e.port = 2'd0; e.err = 1'b0; e.data = 32'd0; end
    ecv = (e.port == 2'd1); edv = (e.port == 2'd2);
    ece = ecv && e.err;     ede = edv && e.err;
    ecd = ecv ? e.data : 32'd0;
    edd = edv ? e.data : 32'd0;
    checks++;
    if (oCRValid !== ecv || oCErr !== ece || oCRData !== ecd ||
        oDRValid !== edv || oDErr !== ede || oDRData !== edd) begin
      errors++;
      $display("FAIL resp_%0d: got C v=%b e=%b d=%h D v=%b e=%b d=%h, want C v=%b e=%b d=%h D v=%b e=%b d=%h",
               tag, oCRValid, oCErr, oCRData, oDRValid, oDErr, oDRData, ecv, ece, ecd, edv, ede, edd);
    end
  endtask

  // Check grant/command outputs, check the response, push the expected response.
  task automatic check_cycle(input logic ecg, edg, ewr, input logic [DW-3:0] ema, input int tag);
    rsp_t        e;
    logic [31:0] a, wd, off;
    logic [3:0]  be;
    logic        we, win;
    logic [DW-3:0] w;
    check_resp(tag);
    checks++;
    if (oCGnt !== ecg || oDGnt !== edg || oMemWren !== ewr || oMemAddr !== ema) begin
      errors++;
      $display("FAIL cmd_%0d: got cgnt=%b dgnt=%b wren=%b addr=%h, want cgnt=%b dgnt=%b wren=%b addr=%h",
               tag, oCGnt, oDGnt, oMemWren, oMemAddr, ecg, edg, ewr, ema);
    end
    a  = ecg ? iCAddr  : iDAddr;
    we = ecg ? iCWe    : iDWe;
    be = ecg ? iCBe    : iDBe;
    wd = ecg ? iCWData : iDWData;
    e.port = ecg ? 2'd1 : (edg ? 2'd2 : 2'd0);
    e.err  = 1'b0;
    e.data = 32'd0;
    if (ecg || edg) begin
      win   = (a >= BEG) && (a <= ENDD);
      e.err = !win;
      off   = (a - BEG) >> 2;
      w     = off[DW-3:0];
      if (win && we) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else if (win) begin
        e.data = ref_mem[w];
      end
    end
    sbq.push_back(e);
  endtask

  // Everything that must be quiet while reset is asserted.
  task automatic check_reset_quiet(input int tag);
    checks++;
    if ({oCGnt, oDGnt, oMemWren, oCRValid, oDRValid, oCErr, oDErr} !== 7'b0 ||
        oCRData !== 32'd0 || oDRData !== 32'd0) begin
      errors++;
      $display("FAIL reset_%0d: got gnt=%b%b wren=%b rv=%b%b err=%b%b cd=%h dd=%h, want all 0",
               tag, oCGnt, oDGnt, oMemWren, oCRValid, oDRValid, oCErr, oDErr, oCRData, oDRData);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0,0,4'h0,BEG,0,                       0,0,4'h0,BEG,0,                     0,0,0,10'h000);
    vt[1]  = mk(1,0,4'hF,BEG+32'd8,0,                 0,0,4'h0,BEG,0,                     1,0,0,10'h002);
    vt[2]  = mk(0,0,4'h0,BEG,0,                       1,1,4'b0011,BEG+32'd4,32'h12345678, 0,1,1,10'h001);
    vt[3]  = mk(0,0,4'h0,BEG,0,                       1,0,4'hF,BEG+32'd4,0,               0,1,0,10'h001);
    vt[4]  = mk(1,0,4'hF,ENDD+32'd4,0,                0,0,4'h0,BEG,0,                     1,0,0,10'h000);
    vt[5]  = mk(1,1,4'hF,ENDD+32'd1,32'hDEADDEAD,     0,0,4'h0,BEG,0,                     1,0,0,10'h000);
    vt[6]  = mk(1,0,4'hF,BEG,0,                       0,0,4'h0,BEG,0,                     1,0,0,10'h000);
    vt[7]  = mk(1,1,4'hF,32'h0000_2FFF,32'hCAFEF00D,  0,0,4'h0,BEG,0,                     1,0,1,10'h3FF);
    vt[8]  = mk(1,0,4'hF,32'h0000_2FFC,0,             0,0,4'h0,BEG,0,                     1,0,0,10'h3FF);
    vt[9]  = mk(1,0,4'hF,BEG-32'd4,0,                 0,0,4'h0,BEG,0,                     1,0,0,10'h3FF);
    vt[10] = mk(0,0,4'h0,BEG,0,                       1,1,4'hF,32'h0000_1000,32'h55555555, 0,1,0,10'h000);
    vt[11] = mk(1,0,4'hF,BEG,0,                       0,0,4'h0,BEG,0,                     1,0,0,10'h000);
    vt[12] = mk(1,0,4'hF,BEG+32'd4,0,                 0,0,4'h0,BEG,0,                     1,0,0,10'h001);
    vt[13] = mk(1,0,4'hF,BEG+32'd8,0,                 0,0,4'h0,BEG,0,                     1,0,0,10'h002);
    vt[14] = mk(1,0,4'hF,BEG+32'd8,0,                 1,0,4'hF,BEG,0,                     1,0,0,10'h002);
    vt[15] = mk(0,0,4'h0,BEG,0,                       1,0,4'hF,BEG,0,                     0,1,0,10'h000);

    for (int i = 0; i < (1 << (DW - 2)); i++) ref_mem[i] = 32'd0;
    ref_mem[2] = 32'hDEADBEEF;

    // Reset with both ports requesting writes: nothing may be granted.
    iRST_N   = 1'b0;
    init_mem = 1'b1;
    drive(1, 1, 4'hF, BEG, 32'h0BAD0BAD, 1, 1, 4'hF, BEG + 32'd4, 32'h0BAD0BAD);
    repeat (2) @(posedge iCLK);
    #1 check_reset_quiet(0);
    @(negedge iCLK) check_reset_quiet(1);
    @(posedge iCLK); #1;
    init_mem = 1'b0;
    drive_idle();
    iRST_N = 1'b1;

    // Vector table.
    for (int i = 0; i < 16; i++) begin
      @(posedge iCLK); #1;
      drive(vt[i].creq, vt[i].cwe, vt[i].cbe, vt[i].caddr, vt[i].cwd,
            vt[i].dreq, vt[i].dwe, vt[i].dbe, vt[i].daddr, vt[i].dwd);
      @(negedge iCLK) check_cycle(vt[i].ecg, vt[i].edg, vt[i].ewr, vt[i].ema, i);
    end

    // Continuous contention: C,C,C,C,D repeating.
    for (int k = 0; k < 10; k++) begin
      @(posedge iCLK); #1 drive_contend();
      @(negedge iCLK) check_cycle(k % 5 != 4, k % 5 == 4, 1'b0,
                                  (k % 5 == 4) ? 10'h001 : 10'h002, 100 + k);
    end
    @(posedge iCLK); #1 drive_idle();
    @(negedge iCLK) check_cycle(0, 0, 0, 10'h000, 110);

    // Reset while D has a partial wait count and a C response is pending.
    for (int k = 0; k < 3; k++) begin
      @(posedge iCLK); #1 drive_contend();
      @(negedge iCLK) check_cycle(1, 0, 0, 10'h002, 200 + k);
    end
    @(posedge iCLK); #1 iRST_N = 1'b0;
    #1 check_reset_quiet(2);
    sbq.delete();
    @(negedge iCLK) check_reset_quiet(3);
    @(posedge iCLK); #1;
    drive_idle();
    iRST_N = 1'b1;
    @(negedge iCLK) check_cycle(0, 0, 0, 10'h000, 210);
    for (int k = 0; k < 5; k++) begin
      @(posedge iCLK); #1 drive_contend();
      @(negedge iCLK) check_cycle(k != 4, k == 4, 1'b0, (k == 4) ? 10'h001 : 10'h002, 220 + k);
    end
    @(posedge iCLK); #1 drive_idle();
    @(negedge iCLK) check_cycle(0, 0, 0, 10'h000, 230);

    // Reset the cycle after a D read grant: its response must never appear.
    @(posedge iCLK); #1 drive(0, 0, 4'h0, BEG, 32'd0, 1, 0, 4'hF, BEG + 32'd8, 32'd0);
    @(negedge iCLK) check_cycle(0, 1, 0, 10'h002, 300);
    @(posedge iCLK); #1;
    iRST_N = 1'b0;
    drive_idle();
    #1 check_reset_quiet(4);
    sbq.delete();
    @(negedge iCLK) check_reset_quiet(5);
    @(posedge iCLK); #1 iRST_N = 1'b1;
    @(negedge iCLK) check_cycle(0, 0, 0, 10'h000, 310);
    @(posedge iCLK); #1 drive_idle();
    @(negedge iCLK) check_cycle(0, 0, 0, 10'h000, 311);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
